// File: rtl/generador_ventana_5x5.sv
// generador_ventana_5x5
//
// Builds 5x5 neighbourhoods from a row-major raster stream so that a 5x5 mask
// convolution stage can process them. Four earlier image rows are kept in a
// line memory. The current window is kept as 25 registers that shift left by
// one column for each accepted pixel. Only interior windows are flagged. No
// border padding is generated.
//
// Ports:
//   clk                 system clock, rising edge
//   reset               synchronous, active-high reset
//   pixel_in            incoming pixel
//   pixel_valido        pixel_in is accepted this cycle
//   inicio_cuadro       accepted pixel is (0, 0) of a new frame (qualified by pixel_valido)
//   pixel_value_1..25   window, row-major; 1 = top-left (oldest), 13 = centre,
//                       25 = bottom-right (newest)
//   ventana_valida      one-cycle strobe: outputs hold a complete interior window
//   columna_centro      column of the window centre
//   fila_centro         row of the window centre
//   fin_cuadro          one-cycle strobe with the last window of the frame
module generador_ventana_5x5 #(
  parameter int unsigned BITS_PIXEL   = 8,
  parameter int unsigned ANCHO_IMAGEN = 640,
  parameter int unsigned ALTO_IMAGEN  = 480,
  parameter int unsigned BITS_COLUMNA = 10,
  parameter int unsigned BITS_FILA    = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BITS_PIXEL-1:0]   pixel_in,
  input  logic                    pixel_valido,
  input  logic                    inicio_cuadro,
  output logic [BITS_PIXEL-1:0]   pixel_value_1,
  output logic [BITS_PIXEL-1:0]   pixel_value_2,
  output logic [BITS_PIXEL-1:0]   pixel_value_3,
  output logic [BITS_PIXEL-1:0]   pixel_value_4,
  output logic [BITS_PIXEL-1:0]   pixel_value_5,
  output logic [BITS_PIXEL-1:0]   pixel_value_6,
  output logic [BITS_PIXEL-1:0]   pixel_value_7,
  output logic [BITS_PIXEL-1:0]   pixel_value_8,
  output logic [BITS_PIXEL-1:0]   pixel_value_9,
  output logic [BITS_PIXEL-1:0]   pixel_value_10,
  output logic [BITS_PIXEL-1:0]   pixel_value_11,
  output logic [BITS_PIXEL-1:0]   pixel_value_12,
  output logic [BITS_PIXEL-1:0]   pixel_value_13,
  output logic [BITS_PIXEL-1:0]   pixel_value_14,
  output logic [BITS_PIXEL-1:0]   pixel_value_15,
  output logic [BITS_PIXEL-1:0]   pixel_value_16,
  output logic [BITS_PIXEL-1:0]   pixel_value_17,
  output logic [BITS_PIXEL-1:0]   pixel_value_18,
  output logic [BITS_PIXEL-1:0]   pixel_value_19,
  output logic [BITS_PIXEL-1:0]   pixel_value_20,
  output logic [BITS_PIXEL-1:0]   pixel_value_21,
  output logic [BITS_PIXEL-1:0]   pixel_value_22,
  output logic [BITS_PIXEL-1:0]   pixel_value_23,
  output logic [BITS_PIXEL-1:0]   pixel_value_24,
  output logic [BITS_PIXEL-1:0]   pixel_value_25,
  output logic                    ventana_valida,
  output logic [BITS_COLUMNA-1:0] columna_centro,
  output logic [BITS_FILA-1:0]    fila_centro,
  output logic                    fin_cuadro
);

  localparam int unsigned BitsDir = (ANCHO_IMAGEN > 1) ? $clog2(ANCHO_IMAGEN) : 1;
  localparam int unsigned BitsLinea = 4 * BITS_PIXEL;

  localparam logic [BITS_COLUMNA-1:0] ColUltima = BITS_COLUMNA'(ANCHO_IMAGEN - 1);
  localparam logic [BITS_FILA-1:0]    FilaUltima = BITS_FILA'(ALTO_IMAGEN - 1);
  localparam logic [BITS_COLUMNA-1:0] ColCuatro = BITS_COLUMNA'(4);
  localparam logic [BITS_FILA-1:0]    FilaCuatro = BITS_FILA'(4);
  localparam logic [BITS_COLUMNA-1:0] ColDos = BITS_COLUMNA'(2);
  localparam logic [BITS_FILA-1:0]    FilaDos = BITS_FILA'(2);

  // Each entry holds {r-4, r-3, r-2, r-1} for one column; r-4 is in the MSBs.
  // The contents are not reset. Counter gating keeps stale rows from being flagged.
  logic [BitsLinea-1:0] linea [ANCHO_IMAGEN];

  logic [BITS_COLUMNA-1:0] col_q, col_d, col_act;
  logic [BITS_FILA-1:0]    fila_q, fila_d, fila_act;
  logic [BitsDir-1:0]      dir;
  logic [BitsLinea-1:0]    entrada;
  logic [BITS_PIXEL-1:0]   columna_nueva [5];
  logic [BITS_PIXEL-1:0]   ventana_q [25];
  logic [BITS_PIXEL-1:0]   ventana_d [25];
  logic                    valida_q, valida_d;
  logic                    fin_q, fin_d;
  logic [BITS_COLUMNA-1:0] col_centro_q, col_centro_d;
  logic [BITS_FILA-1:0]    fila_centro_q, fila_centro_d;
  logic                    interior;

  // inicio_cuadro relabels the current pixel as (0, 0), whatever the counters hold.
  always_comb begin
    col_act  = inicio_cuadro ? '0 : col_q;
    fila_act = inicio_cuadro ? '0 : fila_q;
    dir      = col_act[BitsDir-1:0];
    entrada  = linea[dir];
    columna_nueva[0] = entrada[4*BITS_PIXEL-1 -: BITS_PIXEL];
    columna_nueva[1] = entrada[3*BITS_PIXEL-1 -: BITS_PIXEL];
    columna_nueva[2] = entrada[2*BITS_PIXEL-1 -: BITS_PIXEL];
    columna_nueva[3] = entrada[BITS_PIXEL-1:0];
    columna_nueva[4] = pixel_in;
  end

  always_comb begin
    col_d         = col_q;
    fila_d        = fila_q;
    ventana_d     = ventana_q;
    valida_d      = 1'b0;
    fin_d         = 1'b0;
    col_centro_d  = col_centro_q;
    fila_centro_d = fila_centro_q;
    interior      = (fila_act >= FilaCuatro) && (col_act >= ColCuatro);

    if (pixel_valido) begin
      for (int r = 0; r < 5; r++) begin
        for (int k = 0; k < 4; k++) begin
          ventana_d[r*5+k] = ventana_q[r*5+k+1];
        end
        ventana_d[r*5+4] = columna_nueva[r];
      end

      // Columns 0..3 would mix the previous row's tail into the window.
      valida_d = interior;
      fin_d    = interior && (fila_act == FilaUltima) && (col_act == ColUltima);
      if (interior) begin
        col_centro_d  = col_act - ColDos;
        fila_centro_d = fila_act - FilaDos;
      end

      if (col_act == ColUltima) begin
        col_d  = '0;
        fila_d = (fila_act == FilaUltima) ? '0 : fila_act + 1'b1;
      end else begin
        col_d  = col_act + 1'b1;
        fila_d = fila_act;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q         <= '0;
      fila_q        <= '0;
      valida_q      <= 1'b0;
      fin_q         <= 1'b0;
      col_centro_q  <= '0;
      fila_centro_q <= '0;
      for (int i = 0; i < 25; i++) begin
        ventana_q[i] <= '0;
      end
    end else begin
      col_q         <= col_d;
      fila_q        <= fila_d;
      valida_q      <= valida_d;
      fin_q         <= fin_d;
      col_centro_q  <= col_centro_d;
      fila_centro_q <= fila_centro_d;
      ventana_q     <= ventana_d;
    end
  end

  // Read-before-write: the entry read above feeds the window this cycle, and
  // the entry is rewritten shifted up by one row with the new pixel at the bottom.
  always_ff @(posedge clk) begin
    if (pixel_valido && !reset) begin
      linea[dir] <= {entrada[3*BITS_PIXEL-1:0], pixel_in};
    end
  end

  assign ventana_valida = valida_q;
  assign fin_cuadro     = fin_q;
  assign columna_centro = col_centro_q;
  assign fila_centro    = fila_centro_q;

  assign pixel_value_1  = ventana_q[0];
  assign pixel_value_2  = ventana_q[1];
  assign pixel_value_3  = ventana_q[2];
  assign pixel_value_4  = ventana_q[3];
  assign pixel_value_5  = ventana_q[4];
  assign pixel_value_6  = ventana_q[5];
  assign pixel_value_7  = ventana_q[6];
  assign pixel_value_8  = ventana_q[7];
  assign pixel_value_9  = ventana_q[8];
  assign pixel_value_10 = ventana_q[9];
  assign pixel_value_11 = ventana_q[10];
  assign pixel_value_12 = ventana_q[11];
  assign pixel_value_13 = ventana_q[12];
  assign pixel_value_14 = ventana_q[13];
  assign pixel_value_15 = ventana_q[14];
  assign pixel_value_16 = ventana_q[15];
  assign pixel_value_17 = ventana_q[16];
  assign pixel_value_18 = ventana_q[17];
  assign pixel_value_19 = ventana_q[18];
  assign pixel_value_20 = ventana_q[19];
  assign pixel_value_21 = ventana_q[20];
  assign pixel_value_22 = ventana_q[21];
  assign pixel_value_23 = ventana_q[22];
  assign pixel_value_24 = ventana_q[23];
  assign pixel_value_25 = ventana_q[24];

endmodule

// File: tb/tb_generador_ventana_5x5.sv
// Bench for generador_ventana_5x5 on an 8x6 image whose pixels are fila*16+col.
module tb_generador_ventana_5x5;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       pixel_valido;
  logic       inicio_cuadro;
  logic [7:0] pixel_in;
  logic [7:0] pv1, pv2, pv3, pv4, pv5, pv6, pv7, pv8, pv9, pv10, pv11, pv12, pv13;
  logic [7:0] pv14, pv15, pv16, pv17, pv18, pv19, pv20, pv21, pv22, pv23, pv24, pv25;
  logic       ventana_valida;
  logic [2:0] columna_centro;
  logic [2:0] fila_centro;
  logic       fin_cuadro;
  logic [199:0] win_dut;

  generador_ventana_5x5 #(
    .BITS_PIXEL  (8),
    .ANCHO_IMAGEN(W),
    .ALTO_IMAGEN (H),
    .BITS_COLUMNA(3),
    .BITS_FILA   (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pixel_in      (pixel_in),
    .pixel_valido  (pixel_valido),
    .inicio_cuadro (inicio_cuadro),
    .pixel_value_1 (pv1),
    .pixel_value_2 (pv2),
    .pixel_value_3 (pv3),
    .pixel_value_4 (pv4),
    .pixel_value_5 (pv5),
    .pixel_value_6 (pv6),
    .pixel_value_7 (pv7),
    .pixel_value_8 (pv8),
    .pixel_value_9 (pv9),
    .pixel_value_10(pv10),
    .pixel_value_11(pv11),
    .pixel_value_12(pv12),
    .pixel_value_13(pv13),
    .pixel_value_14(pv14),
    .pixel_value_15(pv15),
    .pixel_value_16(pv16),
    .pixel_value_17(pv17),
    .pixel_value_18(pv18),
    .pixel_value_19(pv19),
    .pixel_value_20(pv20),
    .pixel_value_21(pv21),
    .pixel_value_22(pv22),
    .pixel_value_23(pv23),
    .pixel_value_24(pv24),
    .pixel_value_25(pv25),
    .ventana_valida(ventana_valida),
    .columna_centro(columna_centro),
    .fila_centro   (fila_centro),
    .fin_cuadro    (fin_cuadro)
  );

  assign win_dut = {pv1, pv2, pv3, pv4, pv5, pv6, pv7, pv8, pv9, pv10, pv11, pv12, pv13,
                    pv14, pv15, pv16, pv17, pv18, pv19, pv20, pv21, pv22, pv23, pv24, pv25};

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int strobes = 0;

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: remembers the image as a 2D array and takes each window
  // directly from it.
  logic [7:0]   img [H][W];
  int           pf, pc;
  bit           model_ok = 1'b0;
  bit           win_known;
  bit           exp_valid, exp_fin;
  int           exp_fc, exp_cc;
  logic [199:0] exp_win;

  always @(posedge clk) begin
    if (reset) begin
      model_ok  = 1'b1;
      pf        = 0;
      pc        = 0;
      exp_valid = 1'b0;
      exp_fin   = 1'b0;
      exp_fc    = 0;
      exp_cc    = 0;
      exp_win   = '0;
      win_known = 1'b1;
    end else begin
      exp_valid = 1'b0;
      exp_fin   = 1'b0;
      if (pixel_valido) begin
        if (inicio_cuadro) begin
          pf = 0;
          pc = 0;
        end
        img[pf][pc] = pixel_in;
        if (pf >= 4 && pc >= 4) begin
          exp_valid = 1'b1;
          exp_fin   = (pf == H - 1) && (pc == W - 1);
          exp_fc    = pf - 2;
          exp_cc    = pc - 2;
          for (int r = 0; r < 5; r++)
            for (int k = 0; k < 5; k++)
              exp_win[(24 - (r*5 + k))*8 +: 8] = img[pf-4+r][pc-4+k];
          win_known = 1'b1;
        end else begin
          win_known = 1'b0;
        end
        pc++;
        if (pc == W) begin
          pc = 0;
          pf++;
          if (pf == H) pf = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("cyc_valid", ventana_valida, exp_valid);
      check("cyc_fin", fin_cuadro, exp_fin);
      check("cyc_fila_centro", fila_centro, exp_fc[2:0]);
      check("cyc_col_centro", columna_centro, exp_cc[2:0]);
      if (win_known) check("cyc_window", win_dut, exp_win);
      if (ventana_valida) strobes++;
    end
  end

  task automatic step(input bit v, input bit ini, input logic [7:0] p, input bit r);
    reset         = r;
    pixel_valido  = v;
    inicio_cuadro = ini;
    pixel_in      = p;
    @(posedge clk);
    #1;
  endtask

  // Streams n pixels starting from (0, 0). Pixel value is (fila*16+col)^xv.
  // When gaps is set, idle cycles carrying junk and a stray inicio_cuadro are
  // inserted before each pixel.
  task automatic stream(input int n, input bit ini, input bit gaps, input logic [7:0] xv);
    int f, c;
    logic [7:0] p;
    for (int idx = 0; idx < n; idx++) begin
      f = idx / W;
      c = idx % W;
      if (gaps) begin
        repeat (1 + $urandom_range(0, 3)) step(1'b0, 1'b1, 8'($urandom), 1'b0);
      end
      p = 8'(f*16 + c) ^ xv;
      step(1'b1, ini && (idx == 0), p, 1'b0);
      if (f == 4 && c == 4) begin
        check("first_valid", ventana_valida, 1'b1);
        check("first_v1", pv1, 8'h00 ^ xv);
        check("first_v13", pv13, 8'h22 ^ xv);
        check("first_v25", pv25, 8'h44 ^ xv);
        check("first_fila_centro", fila_centro, 3'd2);
        check("first_col_centro", columna_centro, 3'd2);
      end
      if (f == 5 && c < 4) check("row_wrap_novalid", ventana_valida, 1'b0);
      if (f == 5 && c == 4) begin
        check("row5_v25", pv25, 8'h54 ^ xv);
        check("row5_v1", pv1, 8'h10 ^ xv);
      end
      if (f == 5 && c == 7) begin
        check("last_v1", pv1, 8'h13 ^ xv);
        check("last_v13", pv13, 8'h35 ^ xv);
        check("last_v25", pv25, 8'h57 ^ xv);
        check("last_fila_centro", fila_centro, 3'd3);
        check("last_col_centro", columna_centro, 3'd5);
        check("last_fin", fin_cuadro, 1'b1);
      end
    end
  endtask

  task automatic end_of_frame();
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("fin_one_cycle", fin_cuadro, 1'b0);
    check("strobes_per_frame", strobes, 8);
  endtask

  initial begin
    reset         = 1'b1;
    pixel_valido  = 1'b0;
    inicio_cuadro = 1'b0;
    pixel_in      = 8'h00;
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("reset_window", win_dut, '0);
    check("reset_valid", ventana_valida, 1'b0);
    check("reset_fin", fin_cuadro, 1'b0);
    check("reset_centre", {fila_centro, columna_centro}, 6'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Continuous frame.
    strobes = 0;
    stream(W*H, 1'b0, 1'b0, 8'h00);
    end_of_frame();

    // Same frame with idle bursts between pixels.
    strobes = 0;
    stream(W*H, 1'b0, 1'b1, 8'h00);
    end_of_frame();

    // Restart mid-frame: (3,2) of the old frame carries inicio_cuadro.
    stream(3*W + 2, 1'b0, 1'b0, 8'h00);
    strobes = 0;
    stream(W*H, 1'b1, 1'b0, 8'h80);
    end_of_frame();

    // Reset together with pixel (4,6), then a new frame without inicio_cuadro.
    stream(4*W + 6, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h46, 1'b1);
    check("midreset_window", win_dut, '0);
    check("midreset_valid", ventana_valida, 1'b0);
    check("midreset_fin", fin_cuadro, 1'b0);
    check("midreset_centre", {fila_centro, columna_centro}, 6'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    strobes = 0;
    stream(W*H, 1'b0, 1'b0, 8'h00);
    end_of_frame();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
